// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: walks fill, wash, two rinses and spin,
// handing count-enables to external phase counters and advancing on their
// done flags. Outputs are a pure decode of the registered state and pause.
module wash_cycle_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst,
  input  logic       start_btn,
  input  logic       door_closed,
  input  logic       pause,
  input  logic       fill_done,
  input  logic       wash_done,
  input  logic       rinse_done,
  input  logic       spin_done,
  output logic       start_fill,
  output logic       start_wash,
  output logic       start_rinse,
  output logic       start_spin,
  output logic       round2_rinse,
  output logic       door_lock,
  output logic       cycle_done,
  output logic [2:0] state
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WASH      = 3'd2,
    S_RINSE1    = 3'd3,
    S_RINSE_GAP = 3'd4,
    S_RINSE2    = 3'd5,
    S_SPIN      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; soft abort is folded into the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus output decode. Pause only blocks leaving IDLE: in a
  // phase the state already waits for its done flag, and done wins.
  always_comb begin
    state_d      = state_q;
    start_fill   = 1'b0;
    start_wash   = 1'b0;
    start_rinse  = 1'b0;
    start_spin   = 1'b0;
    round2_rinse = 1'b0;
    door_lock    = 1'b0;
    cycle_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_btn && door_closed && !pause) state_d = S_FILL;
      end
      S_FILL: begin
        start_fill = !pause;
        door_lock  = 1'b1;
        if (fill_done) state_d = S_WASH;
      end
      S_WASH: begin
        start_wash = !pause;
        door_lock  = 1'b1;
        if (wash_done) state_d = S_RINSE1;
      end
      S_RINSE1: begin
        start_rinse = !pause;
        door_lock   = 1'b1;
        if (rinse_done) state_d = S_RINSE_GAP;
      end
      S_RINSE_GAP: begin
        // Reload cycle for the rinse counter; a lingering rinse_done is ignored.
        round2_rinse = 1'b1;
        door_lock    = 1'b1;
        state_d      = S_RINSE2;
      end
      S_RINSE2: begin
        start_rinse = !pause;
        door_lock   = 1'b1;
        if (rinse_done) state_d = S_SPIN;
      end
      S_SPIN: begin
        start_spin = !pause;
        door_lock  = 1'b1;
        if (spin_done) state_d = S_DONE;
      end
      S_DONE: begin
        cycle_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!soft_rst) state_d = S_IDLE;
  end

  assign state = STATE_W'(state_q);

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
No parameters.
REQ-001 clk  in  1  system clock; all state changes occur on the rising edge.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 soft_rst  in  1  synchronous active-low abort; the same polarity as the phase counters' soft_rst.
REQ-004 start_btn  in  1  user start request, level-sampled.
REQ-005 door_closed  in  1  high when the door is shut.
REQ-006 pause  in  1  high freezes the active phase.
REQ-007 fill_done, wash_done, rinse_done, spin_done  in  1 each  level "count reached" flags from the phase counters.
REQ-008 start_fill, start_wash, start_rinse, start_spin  out  1 each  count-enable to the matching phase counter.
REQ-009 round2_rinse  out  1  one-cycle reload strobe to the rinse counter (counter loads 1).
REQ-010 door_lock  out  1  high while any phase is in progress.
REQ-011 cycle_done  out  1  one-cycle completion pulse.
REQ-012 state  out  3  current FSM state code.

Function
REQ-013 The FSM states and codes SHALL be: IDLE=0, FILL=1, WASH=2, RINSE1=3, RINSE_GAP=4, RINSE2=5, SPIN=6, DONE=7.
REQ-014 IDLE->FILL SHALL occur when start_btn=1, door_closed=1, soft_rst=1 and pause=0; otherwise the FSM SHALL stay in IDLE.
REQ-015 FILL->WASH on fill_done=1; WASH->RINSE1 on wash_done=1; RINSE1->RINSE_GAP on rinse_done=1; RINSE2->SPIN on rinse_done=1; SPIN->DONE on spin_done=1.
REQ-016 RINSE_GAP SHALL last exactly one cycle and then go to RINSE2; rinse_done SHALL be ignored in RINSE_GAP.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE, even if start_btn is still high.
REQ-018 Each start_X SHALL equal (state==X and pause==0); RINSE1 and RINSE2 both drive start_rinse.
REQ-019 In RINSE_GAP: start_rinse SHALL be 0, round2_rinse SHALL be 1, and pause SHALL NOT gate round2_rinse; round2_rinse SHALL be 0 in every other state.
REQ-020 door_lock SHALL be 1 in states FILL through SPIN, and 0 in IDLE and DONE.
REQ-021 cycle_done SHALL be 1 only in DONE.
REQ-022 All outputs SHALL be decoded from the registered state plus pause only, with no dependence on the done inputs; a done flag sampled high at edge N moves the state at edge N, and the next phase's start is high in the cycle that follows.
REQ-023 While pause=1:
- the state SHALL hold unless a done flag for the current state is high;
- if that done flag is high, the transition SHALL still be taken (done has priority over pause).
REQ-024 If start_btn deasserts after leaving IDLE, the cycle SHALL continue; door_closed is only checked in IDLE.
REQ-025 Done flags that do not belong to the current state SHALL be ignored.

Reset
REQ-026 When rst_n=0, state SHALL become IDLE asynchronously and all outputs SHALL be 0.
REQ-027 When soft_rst=0 at a rising edge in any state, the next state SHALL be IDLE; this SHALL take priority over every other transition, and the outputs SHALL be 0 from the following cycle.
REQ-028 Reset mid-phase SHALL abandon the cycle, with no cycle_done pulse and door_lock released.

Verification
REQ-029 Full cycle: with door_closed=1, pulse start_btn; return each done flag 5 cycles after its start -> state sequence 0,1,2,3,4,5,6,7,0 with exactly one round2_rinse pulse and one cycle_done pulse.
REQ-030 Door open: start_btn=1, door_closed=0 for 10 cycles -> state stays 0, door_lock=0.
REQ-031 Pause in WASH: pause=1 for 8 cycles -> start_wash=0 and state=2 held, door_lock=1; after release start_wash=1 again.
REQ-032 RINSE_GAP boundary: rinse_done held high across RINSE1->RINSE_GAP->RINSE2 for one cycle, then low -> state reaches 5 and does not skip to 6.
REQ-033 soft_rst=0 for one cycle during SPIN -> state=0 next cycle, all start_* and door_lock are 0, and no cycle_done pulse.
REQ-034 Async reset: drop rst_n mid-clock-period in RINSE2 -> outputs are 0 before the next edge; after release with start_btn=1 the FSM restarts at FILL.
